ps_cmpt_issue: RTL and testbench

Parametrised, pipelined successor to the compute-instruction decoder. Accepts compute instructions over a valid/ready handshake and decodes them into ALU / multiplier / shifter control and register-file addresses. Results are held in one registered output stage. A per-register scoreboard tracks in-flight writes per functional-unit latency and stalls on RAW/WAW hazards. Sits between the program-sequencer fetch stage and the compute units / register-file crossbar.

---
 rtl/ps_cmpt_pkg.sv | 50 +++++
 rtl/ps_cmpt_scoreboard.sv | 50 +++++
 rtl/ps_cmpt_issue.sv | 194 +++++++++++++++++++
 tb/tb_ps_cmpt_issue.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps_cmpt_pkg.sv
// Shared definitions for the compute-instruction issue stage: unit codes,
// instruction field positions, write-enable indices and decoded control layout.
package ps_cmpt_pkg;

  localparam logic [1:0] UNIT_ALU = 2'b00;
  localparam logic [1:0] UNIT_MUL = 2'b01;
  localparam logic [1:0] UNIT_SHF = 2'b10;
  localparam logic [1:0] UNIT_NOP = 2'b11;

  localparam int WE_ALU = 0;
  localparam int WE_MUL = 1;
  localparam int WE_SHF = 2;

  localparam int CNT_W = 3;
  localparam int OP_W  = 7;

  // Field LSB positions; the word is {float, unit, op, dst, rx, ry, sub}.
  function automatic int ry_lsb(input int aw);
    return 2 + 0 * aw;
  endfunction
  function automatic int rx_lsb(input int aw);
    return 2 + aw;
  endfunction
  function automatic int dst_lsb(input int aw);
    return 2 + 2 * aw;
  endfunction
  function automatic int op_lsb(input int aw);
    return 2 + 3 * aw;
  endfunction
  function automatic int unit_lsb(input int aw);
    return 9 + 3 * aw;
  endfunction
  function automatic int float_pos(input int aw);
    return 11 + 3 * aw;
  endfunction

  typedef struct packed {
    logic       cu_float;
    logic [1:0] alu_hc;
    logic [1:0] mul_cls;
    logic [1:0] shf_cls;
    logic [1:0] mul_sc;
    logic [1:0] alu_sc2;
    logic [2:0] alu_sc1;
    logic       mul_otreg;
    logic [3:0] mul_dtsts;
    logic [2:0] w_cuen;
  } ctl_t;

endpackage

// File: rtl/ps_cmpt_scoreboard.sv
// Per-register in-flight write counters; busy also covers a write still held in the output stage.
// A counter loads LAT-1 because the fire cycle itself is the first cycle of the unit latency.
module ps_cmpt_scoreboard
  import ps_cmpt_pkg::*;
#(
  parameter int RF_AW   = 4,
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 3,
  parameter int SHF_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [2:0]            load_we_i,
  input  logic [RF_AW-1:0]      load_addr_i,
  input  logic                  stage_vld_i,
  input  logic [RF_AW-1:0]      stage_addr_i,
  output logic [2**RF_AW-1:0]   busy_o
);

  localparam int NREG = 2 ** RF_AW;
  localparam logic [CNT_W-1:0] ALU_LD = CNT_W'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] SHF_LD = CNT_W'(SHF_LAT - 1);

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [CNT_W-1:0] ld_val;

  always_comb begin
    ld_val = SHF_LD;
    if (load_we_i[WE_ALU])      ld_val = ALU_LD;
    else if (load_we_i[WE_MUL]) ld_val = MUL_LD;
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - CNT_W'(1);
      if (load_i && load_addr_i == RF_AW'(r)) cnt_d[r] = ld_val;
      busy_o[r] = (cnt_q[r] != '0) || (stage_vld_i && stage_addr_i == RF_AW'(r));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '{default: '0};
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ps_cmpt_issue.sv
// Compute-instruction decode/issue: 1-cycle decode into a registered output stage, stalls on RAW/WAW.
// Backpressure: in_ready drops on hazard, flush, or a held stage; PS_CMPT_STATS_EN adds issue/stall counters.
module ps_cmpt_issue
  import ps_cmpt_pkg::*;
#(
  parameter int RF_AW   = 4,
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 3,
  parameter int SHF_LAT = 1,
  localparam int IW     = 12 + 3 * RF_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IW-1:0]    in_inst,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ps_cu_float,
  output logic [1:0]       ps_alu_hc,
  output logic [1:0]       ps_mul_cls,
  output logic [1:0]       ps_shf_cls,
  output logic [1:0]       ps_mul_sc,
  output logic [1:0]       ps_alu_sc2,
  output logic [2:0]       ps_alu_sc1,
  output logic             ps_mul_otreg,
  output logic [3:0]       ps_mul_dtsts,
  output logic [RF_AW-1:0] ps_xb_rd_a0,
  output logic [RF_AW-1:0] ps_xb_raddy,
  output logic [RF_AW-1:0] ps_xb_wrt_a,
  output logic [2:0]       ps_xb_w_cuEn
`ifdef PS_CMPT_STATS_EN
  ,
  output logic [15:0]      stat_issued,
  output logic [15:0]      stat_stalls
`endif
);

  localparam int NREG = 2 ** RF_AW;

  logic             flt;
  logic [1:0]       unit, sub;
  logic [6:0]       op;
  logic [RF_AW-1:0] dst, rx, ry;

  assign flt  = in_inst[float_pos(RF_AW)];
  assign unit = in_inst[unit_lsb(RF_AW) +: 2];
  assign op   = in_inst[op_lsb(RF_AW) +: OP_W];
  assign dst  = in_inst[dst_lsb(RF_AW) +: RF_AW];
  assign rx   = in_inst[rx_lsb(RF_AW) +: RF_AW];
  assign ry   = in_inst[ry_lsb(RF_AW) +: RF_AW];
  assign sub  = in_inst[1:0];

  ctl_t             dec_ctl, ctl_q, ctl_d;
  logic             rx_used, ry_used, dec_wr;
  logic [RF_AW-1:0] dec_ra, dec_rb, dec_wa;
  logic [RF_AW-1:0] ra_q, ra_d, rb_q, rb_d, wa_q, wa_d;
  logic             out_valid_q, out_valid_d;
  logic [NREG-1:0]  busy;
  logic             hazard, in_fire, out_fire;

  always_comb begin
    dec_ctl = '0;
    rx_used = 1'b0;
    ry_used = 1'b0;
    case (unit)
      UNIT_ALU: begin
        dec_ctl.cu_float       = flt;
        dec_ctl.alu_hc         = op[6:5];
        dec_ctl.alu_sc1        = op[3:1];
        dec_ctl.alu_sc2        = {op[4], op[0]};
        dec_ctl.w_cuen[WE_ALU] = !(!op[6] && op[0] && op[2]);
        rx_used                = 1'b1;
        ry_used                = !op[4];
      end
      UNIT_MUL: begin
        dec_ctl.cu_float       = flt;
        dec_ctl.mul_cls        = op[6:5];
        dec_ctl.mul_otreg      = op[4];
        dec_ctl.mul_dtsts      = op[3:0];
        dec_ctl.mul_sc         = sub;
        dec_ctl.w_cuen[WE_MUL] = !op[4];
        rx_used                = (|op[6:5]) || (op[4] && sub != 2'b11);
        ry_used                = |op[6:5];
      end
      UNIT_SHF: begin
        dec_ctl.cu_float       = flt;
        dec_ctl.shf_cls        = op[4:3];
        dec_ctl.w_cuen[WE_SHF] = 1'b1;
        rx_used                = 1'b1;
        ry_used                = !op[4];
      end
      default: ;
    endcase
  end

  assign dec_wr = |dec_ctl.w_cuen;
  assign dec_ra = rx_used ? rx : '0;
  assign dec_rb = ry_used ? ry : '0;
  assign dec_wa = dec_wr ? dst : '0;

  ps_cmpt_scoreboard #(
    .RF_AW  (RF_AW),
    .ALU_LAT(ALU_LAT),
    .MUL_LAT(MUL_LAT),
    .SHF_LAT(SHF_LAT)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .load_i      (out_fire && (|ctl_q.w_cuen)),
    .load_we_i   (ctl_q.w_cuen),
    .load_addr_i (wa_q),
    .stage_vld_i (out_valid_q && (|ctl_q.w_cuen)),
    .stage_addr_i(wa_q),
    .busy_o      (busy)
  );

  assign hazard   = in_valid && ((rx_used && busy[rx]) || (ry_used && busy[ry]) || (dec_wr && busy[dst]));
  // Flush blocks acceptance even with an empty stage so a discard never overlaps a new load.
  assign in_ready = !hazard && !flush && (!out_valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready && !flush;

  always_comb begin
    out_valid_d = out_valid_q;
    ctl_d       = ctl_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    wa_d        = wa_q;
    if (in_fire) begin
      out_valid_d = 1'b1;
      ctl_d       = dec_ctl;
      ra_d        = dec_ra;
      rb_d        = dec_rb;
      wa_d        = dec_wa;
    end else if (out_fire || flush) begin
      out_valid_d = 1'b0;
      ctl_d       = '0;
      ra_d        = '0;
      rb_d        = '0;
      wa_d        = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      ctl_q       <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      wa_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      ctl_q       <= ctl_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      wa_q        <= wa_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign ps_cu_float  = ctl_q.cu_float;
  assign ps_alu_hc    = ctl_q.alu_hc;
  assign ps_mul_cls   = ctl_q.mul_cls;
  assign ps_shf_cls   = ctl_q.shf_cls;
  assign ps_mul_sc    = ctl_q.mul_sc;
  assign ps_alu_sc2   = ctl_q.alu_sc2;
  assign ps_alu_sc1   = ctl_q.alu_sc1;
  assign ps_mul_otreg = ctl_q.mul_otreg;
  assign ps_mul_dtsts = ctl_q.mul_dtsts;
  assign ps_xb_rd_a0  = ra_q;
  assign ps_xb_raddy  = rb_q;
  assign ps_xb_wrt_a  = wa_q;
  assign ps_xb_w_cuEn = ctl_q.w_cuen;

`ifdef PS_CMPT_STATS_EN
  logic [15:0] issued_q, stalls_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issued_q <= '0;
      stalls_q <= '0;
    end else begin
      if (out_fire && issued_q != 16'hFFFF) issued_q <= issued_q + 16'd1;
      if (in_valid && !in_ready && stalls_q != 16'hFFFF) stalls_q <= stalls_q + 16'd1;
    end
  end

  assign stat_issued = issued_q;
  assign stat_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_ps_cmpt_issue.sv
// Directed bench for ps_cmpt_issue with a cycle-level reference model checked every cycle.
module tb_ps_cmpt_issue;

  localparam int AW = 4, IW = 24, ALU_LAT = 1, MUL_LAT = 3, SHF_LAT = 1;

  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [IW-1:0] in_inst = '0;
  logic in_ready, out_valid, ps_cu_float, ps_mul_otreg;
  logic [1:0] ps_alu_hc, ps_mul_cls, ps_shf_cls, ps_mul_sc, ps_alu_sc2;
  logic [2:0] ps_alu_sc1, ps_xb_w_cuEn;
  logic [3:0] ps_mul_dtsts;
  logic [AW-1:0] ps_xb_rd_a0, ps_xb_raddy, ps_xb_wrt_a;
`ifdef PS_CMPT_STATS_EN
  logic [15:0] stat_issued, stat_stalls;
`endif

  always #5 clk = ~clk;

  ps_cmpt_issue #(.RF_AW(AW), .ALU_LAT(ALU_LAT), .MUL_LAT(MUL_LAT), .SHF_LAT(SHF_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .ps_cu_float(ps_cu_float), .ps_alu_hc(ps_alu_hc), .ps_mul_cls(ps_mul_cls),
    .ps_shf_cls(ps_shf_cls), .ps_mul_sc(ps_mul_sc), .ps_alu_sc2(ps_alu_sc2),
    .ps_alu_sc1(ps_alu_sc1), .ps_mul_otreg(ps_mul_otreg), .ps_mul_dtsts(ps_mul_dtsts),
    .ps_xb_rd_a0(ps_xb_rd_a0), .ps_xb_raddy(ps_xb_raddy), .ps_xb_wrt_a(ps_xb_wrt_a),
    .ps_xb_w_cuEn(ps_xb_w_cuEn)
`ifdef PS_CMPT_STATS_EN
    , .stat_issued(stat_issued), .stat_stalls(stat_stalls)
`endif
  );

  logic [33:0] dut_outs;
  assign dut_outs = {ps_cu_float, ps_alu_hc, ps_mul_cls, ps_shf_cls, ps_mul_sc, ps_alu_sc2,
                     ps_alu_sc1, ps_mul_otreg, ps_mul_dtsts, ps_xb_rd_a0, ps_xb_raddy,
                     ps_xb_wrt_a, ps_xb_w_cuEn};

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [IW-1:0] mk(input logic f, input logic [1:0] u, input logic [6:0] op,
                                        input logic [3:0] d, input logic [3:0] x,
                                        input logic [3:0] y, input logic [1:0] s);
    return {f, u, op, d, x, y, s};
  endfunction

  typedef struct packed {
    logic [33:0] outs;
    logic        rxu, ryu;
    logic [2:0]  we;
    logic [3:0]  rx, ry, dst;
  } mdec_t;

  // Decode written straight from the field-mapping rules.
  function automatic mdec_t model_dec(input logic [IW-1:0] w);
    mdec_t m;
    logic [6:0] op;
    logic [1:0] s;
    logic a, mu, sh;
    op = w[20:14];
    s  = w[1:0];
    a  = (w[22:21] == 2'd0);
    mu = (w[22:21] == 2'd1);
    sh = (w[22:21] == 2'd2);
    m.dst = w[13:10];
    m.rx  = w[9:6];
    m.ry  = w[5:2];
    m.we  = {sh, mu & ~op[4], a & ~(~op[6] & op[0] & op[2])};
    m.rxu = a | sh | (mu & ((|op[6:5]) | (op[4] & (s != 2'b11))));
    m.ryu = (a & ~op[4]) | (mu & (|op[6:5])) | (sh & ~op[4]);
    m.outs = {(a | mu | sh) & w[23],
              a ? op[6:5] : 2'b00, mu ? op[6:5] : 2'b00, sh ? op[4:3] : 2'b00,
              mu ? s : 2'b00, a ? {op[4], op[0]} : 2'b00, a ? op[3:1] : 3'b000,
              mu & op[4], mu ? op[3:0] : 4'b0000,
              m.rxu ? m.rx : 4'h0, m.ryu ? m.ry : 4'h0, (|m.we) ? m.dst : 4'h0, m.we};
    return m;
  endfunction

  // Model state: each register is free again from cycle free_at[r].
  longint cyc = 0;
  longint free_at [16];
  logic m_vld = 1'b0;
  mdec_t m_stage = '0;
  int m_iss = 0, m_stl = 0;

  function automatic logic m_busy(input logic [3:0] r);
    return (cyc < free_at[r]) || (m_vld && (|m_stage.we) && m_stage.dst == r);
  endfunction

  always @(negedge clk) begin
    mdec_t e;
    logic haz, exp_rdy, ofire;
    int lat;
    cyc++;
    if (!rst) begin
      m_vld = 1'b0;
      m_stage = '0;
      m_iss = 0;
      m_stl = 0;
      for (int r = 0; r < 16; r++) free_at[r] = 0;
    end
    e = model_dec(in_inst);
    haz = in_valid && ((e.rxu && m_busy(e.rx)) || (e.ryu && m_busy(e.ry)) ||
                       ((|e.we) && m_busy(e.dst)));
    exp_rdy = !haz && !flush && (!m_vld || out_ready);
    chk("model_in_ready", in_ready, exp_rdy);
    chk("model_out_valid", out_valid, m_vld);
    chk("model_outputs", dut_outs, m_vld ? m_stage.outs : 34'd0);
`ifdef PS_CMPT_STATS_EN
    chk("model_stat_issued", stat_issued, m_iss);
    chk("model_stat_stalls", stat_stalls, m_stl);
`endif
    if (rst) begin
      ofire = m_vld && out_ready && !flush;
      if (ofire && (|m_stage.we)) begin
        lat = m_stage.we[0] ? ALU_LAT : (m_stage.we[1] ? MUL_LAT : SHF_LAT);
        free_at[m_stage.dst] = cyc + lat;
      end
      if (ofire && m_iss < 65535) m_iss++;
      if (in_valid && !exp_rdy && m_stl < 65535) m_stl++;
      if (in_valid && exp_rdy) begin
        m_vld = 1'b1;
        m_stage = e;
      end else if (ofire || flush) begin
        m_vld = 1'b0;
        m_stage = '0;
      end
    end
  end

  task automatic step(input logic r, input logic v, input logic [IW-1:0] inst,
                      input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    rst = r; in_valid = v; in_inst = inst; out_ready = ordy; flush = fl;
    @(negedge clk);
  endtask

  logic [IW-1:0] tbl [7];

  initial begin
    // Reset state
    step(0, 0, '0, 0, 0);
    step(0, 0, '0, 0, 0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_outputs", dut_outs, 34'd0);

    // ALU add R3 = R1 + R2
    step(1, 1, mk(0, 2'd0, 7'd0, 4'd3, 4'd1, 4'd2, 2'd0), 1, 0);
    chk("add_in_ready", in_ready, 1'b1);
    step(1, 0, '0, 1, 0);
    chk("add_out_valid", out_valid, 1'b1);
    chk("add_rd_a0", ps_xb_rd_a0, 4'd1);
    chk("add_raddy", ps_xb_raddy, 4'd2);
    chk("add_wrt_a", ps_xb_wrt_a, 4'd3);
    chk("add_w_cuEn", ps_xb_w_cuEn, 3'b001);
    step(1, 0, '0, 1, 0);

    // MUL to R5, then dependent ALU reading R5: refused for 3 cycles from the MUL fire
    step(1, 1, mk(0, 2'd1, 7'b0100000, 4'd5, 4'd1, 4'd2, 2'd0), 1, 0);
    step(1, 1, mk(0, 2'd0, 7'd0, 4'd6, 4'd5, 4'd0, 2'd0), 1, 0);
    chk("raw_stall_t", in_ready, 1'b0);
    step(1, 1, mk(0, 2'd0, 7'd0, 4'd6, 4'd5, 4'd0, 2'd0), 1, 0);
    chk("raw_stall_t1", in_ready, 1'b0);
    step(1, 1, mk(0, 2'd0, 7'd0, 4'd6, 4'd5, 4'd0, 2'd0), 1, 0);
    chk("raw_stall_t2", in_ready, 1'b0);
    step(1, 1, mk(0, 2'd0, 7'd0, 4'd6, 4'd5, 4'd0, 2'd0), 1, 0);
    chk("raw_accept_t3", in_ready, 1'b1);
    step(1, 0, '0, 1, 0);

    // MUL to MRF with no operands: no enables, no addresses, no stall for a reader of its dst
    step(1, 1, mk(0, 2'd1, 7'b0010000, 4'd9, 4'd4, 4'd4, 2'd3), 1, 0);
    step(1, 1, mk(0, 2'd0, 7'd0, 4'd10, 4'd9, 4'd9, 2'd0), 1, 0);
    chk("mrf_w_cuEn", ps_xb_w_cuEn, 3'b000);
    chk("mrf_addrs", {ps_xb_rd_a0, ps_xb_raddy, ps_xb_wrt_a}, 12'h000);
    chk("mrf_otreg_sc", {ps_mul_otreg, ps_mul_sc}, 3'b111);
    chk("mrf_reader_ready", in_ready, 1'b1);

    // Output stage held for 4 cycles while another instruction is offered
    step(1, 1, mk(1, 2'd2, 7'b0011000, 4'd11, 4'd12, 4'd13, 2'd0), 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, mk(0, 2'd0, 7'h40, 4'd14, 4'd1, 4'd2, 2'd0), 0, 0);
      chk("hold_in_ready", in_ready, 1'b0);
      chk("hold_shf_fields", {ps_cu_float, ps_shf_cls, ps_xb_w_cuEn}, 6'b1_11_100);
      chk("hold_addrs", {ps_xb_rd_a0, ps_xb_raddy, ps_xb_wrt_a}, 12'hC0B);
    end
    step(1, 1, mk(0, 2'd0, 7'h40, 4'd14, 4'd1, 4'd2, 2'd0), 1, 0);
    chk("hold_release_ready", in_ready, 1'b1);
`ifdef PS_CMPT_STATS_EN
    chk("stat_stalls_after_hold", stat_stalls, 16'd7);  // 3 from the RAW pair + 4 held
`endif
    step(1, 0, '0, 1, 0);

    // Flush of a SHF to R7; a following reader of R7 issues without stalling
    step(1, 1, mk(0, 2'd2, 7'd0, 4'd7, 4'd1, 4'd2, 2'd0), 1, 0);
    step(1, 1, mk(0, 2'd0, 7'd0, 4'd8, 4'd7, 4'd7, 2'd0), 1, 1);
    chk("flush_out_valid_before", out_valid, 1'b1);
    chk("flush_in_ready", in_ready, 1'b0);
    step(1, 1, mk(0, 2'd0, 7'd0, 4'd8, 4'd7, 4'd7, 2'd0), 1, 0);
    chk("flush_out_valid_after", out_valid, 1'b0);
    chk("flush_reader_ready", in_ready, 1'b1);
    step(1, 0, '0, 1, 0);

    // Reset in the middle of a MUL latency window
    step(1, 1, mk(0, 2'd1, 7'b0100000, 4'd5, 4'd1, 4'd2, 2'd0), 1, 0);
    step(1, 0, '0, 1, 0);
    step(0, 0, '0, 1, 0);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_outputs", dut_outs, 34'd0);
`ifdef PS_CMPT_STATS_EN
    chk("midrst_stat_issued", stat_issued, 16'd0);
`endif
    step(1, 1, mk(0, 2'd0, 7'd0, 4'd6, 4'd5, 4'd5, 2'd0), 1, 0);
    chk("midrst_reader_ready", in_ready, 1'b1);
    step(1, 0, '0, 1, 0);

    // Mixed stream: no-write ALU, ALU without Ry, MUL, MRF MUL with Rx, SHF, NOP, R4 reader
    tbl[0] = mk(0, 2'd0, 7'b0000101, 4'd1, 4'd2, 4'd3, 2'd0);
    tbl[1] = mk(1, 2'd0, 7'b1111111, 4'd2, 4'd3, 4'd4, 2'd1);
    tbl[2] = mk(0, 2'd1, 7'b1101010, 4'd4, 4'd5, 4'd6, 2'd2);
    tbl[3] = mk(0, 2'd1, 7'b0010000, 4'd7, 4'd8, 4'd9, 2'd1);
    tbl[4] = mk(1, 2'd2, 7'b0001000, 4'd10, 4'd11, 4'd12, 2'd0);
    tbl[5] = mk(0, 2'd3, 7'h7F, 4'd13, 4'd14, 4'd15, 2'd3);
    tbl[6] = mk(0, 2'd0, 7'd0, 4'd4, 4'd4, 4'd1, 2'd0);
    for (int i = 0; i < 7; i++) begin
      int n;
      n = 0;
      step(1, 1, tbl[i], 1, 0);
      while (!in_ready && n < 10) begin
        n++;
        step(1, 1, tbl[i], 1, 0);
      end
      chk("stream_accept_bound", n < 10, 1'b1);
    end
    step(1, 0, '0, 1, 0);
    step(1, 0, '0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
